// File: rtl/store_buf_pkg.sv
// Shared types and defaults for the posted-write store buffer.
package store_buf_pkg;
    localparam int XLEN             = 32;
    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [XLEN-3:0] waddr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      be;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// M-stage load/store and data-memory ports of the store buffer, grouped as one bundle.
interface store_buffer_if;
    import store_buf_pkg::*;

    logic            MemWrite;
    logic            MemRead;
    logic [3:0]      MemWriteSelect;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] ReadDataM;
    logic            StoreStall;
    logic            BufEmpty;
    logic [XLEN-1:0] mem_raddr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_wvalid;
    logic            mem_wready;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wbe;

    modport slave (
        input  MemWrite, MemRead, MemWriteSelect, ALUResultM, WriteDataM,
        input  mem_rdata, mem_wready,
        output ReadDataM, StoreStall, BufEmpty,
        output mem_raddr, mem_wvalid, mem_waddr, mem_wdata, mem_wbe
    );

    modport master (
        output MemWrite, MemRead, MemWriteSelect, ALUResultM, WriteDataM,
        output mem_rdata, mem_wready,
        input  ReadDataM, StoreStall, BufEmpty,
        input  mem_raddr, mem_wvalid, mem_waddr, mem_wdata, mem_wbe
    );
endinterface

// File: rtl/store_buf_fwd.sv
// Per-lane load forwarding: each byte comes from the youngest matching buffered store, else memory.
// Purely combinational; entries are scanned oldest-to-youngest so later matches overwrite earlier ones.
module store_buf_fwd
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int IW    = $clog2(DEPTH)
) (
    input  sb_entry_t        entries_i [DEPTH],
    input  logic [DEPTH-1:0] vld_i,
    input  logic [IW-1:0]    rd_idx_i,
    input  logic             mem_read_i,
    input  logic [XLEN-3:0]  laddr_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    output logic [XLEN-1:0]  rdata_o
);
    logic [IW-1:0] idx;

    always_comb begin
        rdata_o = mem_rdata_i;
        idx     = '0;
        if (mem_read_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_idx_i + IW'(i);
                if (vld_i[idx] && (entries_i[idx].waddr == laddr_i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (entries_i[idx].be[b]) begin
                            rdata_o[8*b +: 8] = entries_i[idx].wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: stores queue in a FIFO and drain in order over valid/ready; loads merge buffered bytes.
// A store is presentable one cycle after enqueue; a full buffer stalls the store unless the head pops that cycle.
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    sb_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    logic [IW-1:0]    wr_idx, rd_idx;
    logic             empty, full, push, pop;
    sb_entry_t        new_entry, head;

    assign wr_idx = wr_ptr_q[IW-1:0];
    assign rd_idx = rd_ptr_q[IW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);

    assign pop           = sb.mem_wvalid & sb.mem_wready;
    assign sb.StoreStall = sb.MemWrite & full & ~pop;
    assign push          = sb.MemWrite & ~sb.StoreStall;

    assign new_entry.waddr = sb.ALUResultM[XLEN-1:2];
    assign new_entry.wdata = sb.WriteDataM << {sb.ALUResultM[1:0], 3'b000};
    assign new_entry.be    = sb.MemWriteSelect;

    assign head          = entries_q[rd_idx];
    assign sb.mem_wvalid = ~empty;
    assign sb.mem_waddr  = {head.waddr, 2'b00};
    assign sb.mem_wdata  = head.wdata;
    assign sb.mem_wbe    = head.be;
    assign sb.BufEmpty   = empty;
    assign sb.mem_raddr  = {sb.ALUResultM[XLEN-1:2], 2'b00};

    // Clear before set: when full, push and pop hit the same slot and it must stay valid.
    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
        if (pop)  vld_d[rd_idx] = 1'b0;
        if (push) vld_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            if (push) begin
                entries_q[wr_idx] <= new_entry;
            end
        end
    end

    // Only registered entries forward, so a store accepted this cycle is invisible to the load.
    store_buf_fwd #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fwd (
        .entries_i   (entries_q),
        .vld_i       (vld_q),
        .rd_idx_i    (rd_idx),
        .mem_read_i  (sb.MemRead),
        .laddr_i     (sb.ALUResultM[XLEN-1:2]),
        .mem_rdata_i (sb.mem_rdata),
        .rdata_o     (sb.ReadDataM)
    );
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain, full/stall, forwarding, hold-under-backpressure, async reset.
module tb_store_buffer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.MemWrite       = 1'b1;
        bus.MemRead        = 1'b0;
        bus.ALUResultM     = a;
        bus.WriteDataM     = d;
        bus.MemWriteSelect = be;
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] mem);
        bus.MemWrite   = 1'b0;
        bus.MemRead    = 1'b1;
        bus.ALUResultM = a;
        bus.mem_rdata  = mem;
    endtask

    task automatic idle;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
    endtask

    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        reset              = 1'b1;
        bus.MemWrite       = 1'b0;
        bus.MemRead        = 1'b0;
        bus.MemWriteSelect = 4'h0;
        bus.ALUResultM     = '0;
        bus.WriteDataM     = '0;
        bus.mem_rdata      = '0;
        bus.mem_wready     = 1'b0;
        #3;
        chk("rst_bufempty", {31'd0, bus.BufEmpty}, 32'd1);
        chk("rst_wvalid", {31'd0, bus.mem_wvalid}, 32'd0);
        chk("rst_stall", {31'd0, bus.StoreStall}, 32'd0);
        step;
        reset = 1'b0;
        step;

        // Test 1: single word store drains immediately.
        bus.mem_wready = 1'b1;
        st(32'h100, 32'hDEADBEEF, 4'hF);
        #1;
        chk("t1_nostall", {31'd0, bus.StoreStall}, 32'd0);
        chk("t1_wvalid_same_cycle", {31'd0, bus.mem_wvalid}, 32'd0);
        step;
        idle;
        #1;
        chk("t1_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
        chk("t1_waddr", bus.mem_waddr, 32'h100);
        chk("t1_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("t1_wbe", {28'd0, bus.mem_wbe}, 32'hF);
        chk("t1_notempty", {31'd0, bus.BufEmpty}, 32'd0);
        step;
        #1;
        chk("t1_empty", {31'd0, bus.BufEmpty}, 32'd1);
        chk("t1_wvalid_off", {31'd0, bus.mem_wvalid}, 32'd0);

        // Test 2: fill, stall the fifth, accept it in the pop cycle.
        bus.mem_wready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            st(32'h400 + 32'(4 * k), 32'(k + 1), 4'hF);
            #1;
            chk("t2_fill_nostall", {31'd0, bus.StoreStall}, 32'd0);
            step;
        end
        st(32'h410, 32'h55, 4'hF);
        #1;
        chk("t2_stall", {31'd0, bus.StoreStall}, 32'd1);
        step;
        chk("t2_stall_held", {31'd0, bus.StoreStall}, 32'd1);
        bus.mem_wready = 1'b1;
        #1;
        chk("t2_stall_released", {31'd0, bus.StoreStall}, 32'd0);
        chk("t2_head0", bus.mem_waddr, 32'h400);
        step;
        bus.mem_wready = 1'b0;
        st(32'h420, 32'h99, 4'hF);
        #1;
        chk("t2_still_full", {31'd0, bus.StoreStall}, 32'd1);
        idle;
        exp_addr[0] = 32'h404; exp_data[0] = 32'h2;
        exp_addr[1] = 32'h408; exp_data[1] = 32'h3;
        exp_addr[2] = 32'h40C; exp_data[2] = 32'h4;
        exp_addr[3] = 32'h410; exp_data[3] = 32'h55;
        bus.mem_wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_drain_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
            chk("t2_drain_waddr", bus.mem_waddr, exp_addr[k]);
            chk("t2_drain_wdata", bus.mem_wdata, exp_data[k]);
            step;
        end
        chk("t2_empty", {31'd0, bus.BufEmpty}, 32'd1);

        // Test 3: sb + sh merge into one load word.
        bus.mem_wready = 1'b0;
        st(32'h203, 32'h000000AA, 4'b1000);
        step;
        st(32'h200, 32'h00001234, 4'b0011);
        step;
        ld(32'h200, 32'h55667788);
        #1;
        chk("t3_merge", bus.ReadDataM, 32'hAA661234);
        chk("t3_raddr", bus.mem_raddr, 32'h200);
        bus.MemRead = 1'b0;
        #1;
        chk("t3_noread_passthru", bus.ReadDataM, 32'h55667788);
        bus.mem_wready = 1'b1;
        chk("t3_head_sb_data", bus.mem_wdata, 32'hAA000000);
        chk("t3_head_sb_be", {28'd0, bus.mem_wbe}, 32'h8);
        step;
        chk("t3_head_sh_data", bus.mem_wdata, 32'h00001234);
        chk("t3_head_sh_be", {28'd0, bus.mem_wbe}, 32'h3);
        step;
        chk("t3_empty", {31'd0, bus.BufEmpty}, 32'd1);

        // Test 4: youngest match wins; the popping entry still forwards.
        bus.mem_wready = 1'b0;
        st(32'h301, 32'h11, 4'b0010);
        step;
        st(32'h301, 32'h22, 4'b0010);
        step;
        ld(32'h301, 32'hA0B0C0D0);
        #1;
        chk("t4_youngest", bus.ReadDataM, 32'hA0B022D0);
        bus.mem_wready = 1'b1;
        step;
        chk("t4_fwd_while_pop", bus.ReadDataM, 32'hA0B022D0);
        step;
        chk("t4_after_drain", bus.ReadDataM, 32'hA0B0C0D0);
        idle;

        // Test 5: head held stable under backpressure.
        bus.mem_wready = 1'b0;
        st(32'h500, 32'hCAFEF00D, 4'hF);
        step;
        st(32'h504, 32'h12345678, 4'hF);
        step;
        idle;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
            chk("t5_waddr", bus.mem_waddr, 32'h500);
            chk("t5_wdata", bus.mem_wdata, 32'hCAFEF00D);
            chk("t5_wbe", {28'd0, bus.mem_wbe}, 32'hF);
            step;
        end

        // Test 6: async reset with three pending entries.
        st(32'h508, 32'h0BADF00D, 4'hF);
        step;
        idle;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_wvalid_drop", {31'd0, bus.mem_wvalid}, 32'd0);
        chk("t6_bufempty", {31'd0, bus.BufEmpty}, 32'd1);
        step;
        reset = 1'b0;
        bus.mem_wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t6_no_write", {31'd0, bus.mem_wvalid}, 32'd0);
            step;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
